i2c_cmd_arbiter: RTL and testbench

Shares the single I2C_Controller instance between up to NUM_REQ command sources: the boot-time codec configuration sequencer, runtime headphone-volume control and others. Each requester presents a 24-bit I2C word {device address, register address, data}. The block grants the bus round-robin, drives GO and I2C_DATA, and tracks the controller's END handshake. It enforces a minimum inter-transaction gap, aborts hung transfers with a timeout, and reports completion or error to the owning requester.

---
 rtl/i2c_cmd_arbiter_if.sv | 10 +
 rtl/i2c_cmd_arbiter.sv | 97 +++++++++
 tb/tb_i2c_cmd_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: requester handshake and I2C_Controller signals around the command arbiter
interface i2c_cmd_arbiter_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0] req, ack, err;
  logic [24*NUM_REQ-1:0] req_data;
  logic [2:0] owner;
  logic busy, i2c_go, i2c_end;
  logic [23:0] i2c_data;
  modport master (output req, req_data, i2c_end, input ack, err, owner, busy, i2c_data, i2c_go);
  modport slave (input req, req_data, i2c_end, output ack, err, owner, busy, i2c_data, i2c_go);
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C_Controller with gap enforcement and timeout abort
module i2c_cmd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input logic CLOCK_50,
  input logic resetn,
  i2c_cmd_arbiter_if.slave bus
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES) + 1);
  localparam int TW = CW > 18 ? CW : 18;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, BUSY = 3'd2, DONE = 3'd3, ABORT = 3'd4, GAP = 3'd5;
  logic [2:0] state, owner, nxt;
  logic [TW-1:0] timer;
  logic [23:0] data, word;
  logic [NUM_REQ-1:0] ack, err;
  logic go, hit;
  int d, best;
  // nearest set request after the last owner wins, so the last owner has lowest priority
  always_comb begin
    hit = 1'b0;
    nxt = owner;
    word = '0;
    d = 0;
    best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + 2 * NUM_REQ - int'(owner) - 1) % NUM_REQ;
      if (bus.req[j] && d < best) begin
        best = d;
        nxt = 3'(j);
        word = bus.req_data[24*j +: 24];
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      timer <= '0;
      owner <= 3'(NUM_REQ - 1);
      data <= '0;
      go <= 1'b0;
      ack <= '0;
      err <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      timer <= timer + TW'(~&timer);
      case (state)
        IDLE: if (hit) begin
          owner <= nxt;
          data <= word;
          go <= 1'b1;
          timer <= '0;
          state <= START;
        end
        START: if (!bus.i2c_end) begin
          timer <= '0;
          state <= BUSY;
        end else if (timer == TW'(TIMEOUT_CYCLES)) begin
          timer <= '0;
          state <= ABORT;
        end
        BUSY: if (bus.i2c_end) begin
          timer <= '0;
          state <= DONE;
        end else if (timer == TW'(TIMEOUT_CYCLES)) begin
          timer <= '0;
          state <= ABORT;
        end
        DONE: begin
          go <= 1'b0;
          ack <= NUM_REQ'(1) << owner;
          timer <= '0;
          state <= GAP;
        end
        ABORT: begin
          go <= 1'b0;
          err <= NUM_REQ'(1) << owner;
          timer <= '0;
          state <= GAP;
        end
        GAP: if (timer == TW'(GAP_CYCLES)) begin
          timer <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.ack = ack;
  assign bus.err = err;
  assign bus.owner = owner;
  assign bus.busy = state != IDLE;
  assign bus.i2c_data = data;
  assign bus.i2c_go = go;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed checks of grant order, handshake timing, gap, timeout and reset
module tb_i2c_cmd_arbiter;
  localparam int N = 3, G = 8, T = 64;
  localparam logic [23:0] W0 = 24'h341E00, W1 = 24'h3412AB, W2 = 24'h340C55, W3 = 24'h34AA01;
  logic CLOCK_50 = 1'b0, resetn = 1'b0;
  int checks = 0, errors = 0, go_cycles = 0, ack_pulses = 0, multi = 0;
  i2c_cmd_arbiter_if #(.NUM_REQ(N)) bus();
  i2c_cmd_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(negedge CLOCK_50) begin
    if (bus.i2c_go === 1'b1) go_cycles++;
    if (bus.ack != 0) ack_pulses++;
    if ($countones(bus.ack | bus.err) > 1) multi++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask
  task automatic wait_go(input int who, input logic [23:0] w);
    int k = 0;
    while (bus.i2c_go !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("grant_seen", 32'(bus.i2c_go), 1);
    chk("grant_owner", 32'(bus.owner), who);
    chk("grant_data", 32'(bus.i2c_data), 32'(w));
  endtask
  task automatic serve(input int who, input logic [23:0] w);
    wait_go(who, w);
    bus.i2c_end = 1'b0;
    tick(1);
    bus.i2c_end = 1'b1;
    tick(2);
    chk("ack_owner", 32'(bus.ack), 32'(1) << who);
    chk("ack_go_low", 32'(bus.i2c_go), 0);
    chk("ack_no_err", 32'(bus.err), 0);
    bus.req[who] = 1'b0;
  endtask
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.i2c_end = 1'b1;
    tick(2);
    chk("rst_go", 32'(bus.i2c_go), 0);
    chk("rst_data", 32'(bus.i2c_data), 0);
    chk("rst_ackerr", 32'({bus.ack, bus.err}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 2);
    resetn = 1'b1;
    tick(1);
    bus.req_data[23:0] = W0;
    bus.req = 3'b001;
    tick(1);
    chk("single_go", 32'(bus.i2c_go), 1);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_data", 32'(bus.i2c_data), 32'(W0));
    chk("single_owner", 32'(bus.owner), 0);
    tick(4);
    bus.i2c_end = 1'b0;
    tick(40);
    bus.i2c_end = 1'b1;
    tick(1);
    chk("single_go_done", 32'(bus.i2c_go), 1);
    chk("single_no_ack_yet", 32'(bus.ack), 0);
    tick(1);
    chk("single_go_low", 32'(bus.i2c_go), 0);
    chk("single_ack", 32'(bus.ack), 1);
    chk("single_gap_busy", 32'(bus.busy), 1);
    bus.req = '0;
    tick(G);
    chk("single_gap_end_busy", 32'(bus.busy), 1);
    tick(1);
    chk("single_idle", 32'(bus.busy), 0);
    chk("single_go_cycles", 32'(go_cycles), 46);
    chk("single_ack_pulses", 32'(ack_pulses), 1);
    bus.req = 3'b001;
    tick(1);
    chk("rstb_go", 32'(bus.i2c_go), 1);
    bus.i2c_end = 1'b0;
    tick(1);
    #1 resetn = 1'b0;
    #1;
    chk("rstb_go_async", 32'(bus.i2c_go), 0);
    chk("rstb_busy", 32'(bus.busy), 0);
    chk("rstb_owner", 32'(bus.owner), 2);
    chk("rstb_data", 32'(bus.i2c_data), 0);
    chk("rstb_ackerr", 32'({bus.ack, bus.err}), 0);
    tick(1);
    resetn = 1'b1;
    bus.i2c_end = 1'b1;
    bus.req_data = {W2, W1, W0};
    bus.req = 3'b111;
    serve(0, W0);
    tick(1);
    bus.req[0] = 1'b1;
    serve(1, W1);
    tick(1);
    bus.req[1] = 1'b1;
    serve(2, W2);
    tick(1);
    bus.req[2] = 1'b1;
    serve(0, W0);
    bus.req = '0;
    tick(G + 2);
    bus.req_data[47:24] = W3;
    bus.req = 3'b010;
    wait_go(1, W3);
    bus.req[1] = 1'b0;
    bus.req_data[47:24] = 24'h123456;
    bus.i2c_end = 1'b0;
    tick(1);
    chk("drop_data_held", 32'(bus.i2c_data), 32'(W3));
    bus.i2c_end = 1'b1;
    tick(2);
    chk("drop_ack", 32'(bus.ack), 3'b010);
    chk("drop_data_end", 32'(bus.i2c_data), 32'(W3));
    tick(G + 2);
    bus.req = 3'b100;
    wait_go(2, W2);
    tick(T + 1);
    chk("tmo_start_go", 32'(bus.i2c_go), 1);
    chk("tmo_start_pre", 32'(bus.err), 0);
    tick(1);
    chk("tmo_start_err", 32'(bus.err), 3'b100);
    chk("tmo_start_golow", 32'(bus.i2c_go), 0);
    chk("tmo_start_noack", 32'(bus.ack), 0);
    bus.req = '0;
    tick(G + 2);
    bus.req = 3'b001;
    wait_go(0, W0);
    bus.i2c_end = 1'b0;
    tick(T + 2);
    chk("tmo_busy_go", 32'(bus.i2c_go), 1);
    chk("tmo_busy_pre", 32'(bus.err), 0);
    tick(1);
    chk("tmo_busy_err", 32'(bus.err), 3'b001);
    chk("tmo_busy_golow", 32'(bus.i2c_go), 0);
    chk("tmo_busy_noack", 32'(bus.ack), 0);
    bus.i2c_end = 1'b1;
    bus.req = 3'b100;
    tick(G + 1);
    chk("gap_no_go", 32'(bus.i2c_go), 0);
    tick(1);
    chk("gap_go", 32'(bus.i2c_go), 1);
    chk("gap_owner", 32'(bus.owner), 2);
    bus.i2c_end = 1'b0;
    tick(1);
    bus.i2c_end = 1'b1;
    tick(2);
    chk("gap_ack", 32'(bus.ack), 3'b100);
    bus.req = '0;
    tick(2);
    chk("ack_err_exclusive", 32'(multi), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
